// File: rtl/core_pkg.sv
// Shared types and constants for the core front end.
package core_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // RUN: nothing outstanding, WAIT: one fetch in flight, KILL: in-flight fetch to discard
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    KILL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: request/accept handshake plus in-order read response.
interface fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            req;
  logic [XLEN-1:0] addr;
  logic            ready;
  logic            rvalid;
  logic [31:0]     rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/fetch_buffer.sv
// Single-entry holding register for one fetched instruction, its PC and PC+4.
module fetch_buffer
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            consume,
  input  logic            flush,
  input  logic [XLEN-1:0] wr_pc,
  input  logic [31:0]     wr_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc_plus4
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_plus4_q;

  // A write in the same edge as a consume wins, so back-to-back delivery never drops a slot
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= 1'b0;
    end else if (wr_en) begin
      valid_q <= 1'b1;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      instr_q    <= INSTR_NOP;
      pc_plus4_q <= '0;
    end else if (wr_en && !flush) begin
      pc_q       <= wr_pc;
      instr_q    <= wr_instr;
      pc_plus4_q <= wr_pc + XLEN'(4);
    end
  end

  // Downstream sees a NOP bubble with zeroed PCs whenever the slot is empty
  assign valid    = valid_q;
  assign pc       = valid_q ? pc_q       : '0;
  assign instr    = valid_q ? instr_q    : INSTR_NOP;
  assign pc_plus4 = valid_q ? pc_plus4_q : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads to instruction memory and
// hands one fetched instruction at a time to the IF/ID register.
module fetch_unit
  import core_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  fetch_unit_if.master      imem,
  output logic              if_valid_o,
  output logic [XLEN-1:0]   if_pc_o,
  output logic [31:0]       if_instr_o,
  output logic [XLEN-1:0]   if_pc_plus4_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_pc_q;
  logic            buf_valid;
  logic            accept;
  logic            resp_write;
  logic            consume;

  // Issue only when the buffer will be empty after this edge, so a response always has room
  assign imem.req   = !rst && (state_q == RUN) && !redirect_i && (!buf_valid || !stall_i);
  assign imem.addr  = pc_q;
  assign accept     = imem.req && imem.ready;
  assign resp_write = (state_q == WAIT) && imem.rvalid && !redirect_i;
  assign consume    = buf_valid && !stall_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (accept) state_d = WAIT;
      end
      WAIT: begin
        if (imem.rvalid)     state_d = RUN;
        else if (redirect_i) state_d = KILL;
      end
      KILL: begin
        if (imem.rvalid) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_i) begin
        pc_q <= redirect_pc_i & ~XLEN'(3);
      end else if (accept) begin
        pc_q <= pc_q + XLEN'(4);
      end
      if (accept) begin
        pend_pc_q <= pc_q;
      end
    end
  end

  fetch_buffer #(
    .XLEN(XLEN)
  ) u_buffer (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (resp_write),
    .consume  (consume),
    .flush    (redirect_i),
    .wr_pc    (pend_pc_q),
    .wr_instr (imem.rdata),
    .valid    (buf_valid),
    .pc       (if_pc_o),
    .instr    (if_instr_o),
    .pc_plus4 (if_pc_plus4_o)
  );

  assign if_valid_o = buf_valid;

  // A response with nothing outstanding means the memory broke the in-order contract
  a_no_rvalid_in_run: assert property (@(posedge clk) disable iff (rst)
    !((state_q == RUN) && imem.rvalid));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory handshake is driven cycle by cycle from each scenario task.
module tb_fetch_unit;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;

  int total = 0;
  int bad = 0;

  fetch_unit_if #(.XLEN(32)) mem ();

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem          (mem),
    .if_valid_o    (if_valid),
    .if_pc_o       (if_pc),
    .if_instr_o    (if_instr),
    .if_pc_plus4_o (if_pc_plus4)
  );

  always #5 clk = ~clk;

  // Memory image: every word is a distinct, address-derived pattern
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_1013;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0;
    mem.ready = 1'b0; mem.rvalid = 1'b0; mem.rdata = '0;
    tick(); tick();
    total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", if_valid); end
    total++; if ({if_pc, if_pc_plus4} !== 64'h0) begin bad++; $display("[TB] FAIL reset_pc got=%h/%h exp=0/0", if_pc, if_pc_plus4); end
    total++; if (if_instr !== 32'h0000_0013) begin bad++; $display("[TB] FAIL reset_instr got=%h exp=00000013", if_instr); end
    total++; if ({mem.req, mem.addr} !== 33'h0) begin bad++; $display("[TB] FAIL reset_req got=%b/%h exp=0/0", mem.req, mem.addr); end
  endtask

  task automatic test_stream();
    logic [31:0] a;
    mem.ready = 1'b1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = 32'(k) * 32'd4;
      #1;
      total++; if ({mem.req, mem.addr} !== {1'b1, a}) begin bad++; $display("[TB] FAIL stream_req%0d got=%b/%h exp=1/%h", k, mem.req, mem.addr, a); end
      tick();
      mem.rvalid = 1'b1; mem.rdata = word_of(a);
      total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL stream_gap%0d got=%b exp=0", k, if_valid); end
      #1;
      total++; if (mem.req !== 1'b0) begin bad++; $display("[TB] FAIL stream_wait%0d got=%b exp=0", k, mem.req); end
      tick();
      mem.rvalid = 1'b0;
      total++; if ({if_valid, if_pc, if_instr, if_pc_plus4} !== {1'b1, a, word_of(a), a + 32'd4}) begin
        bad++; $display("[TB] FAIL stream_out%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", k, if_valid, if_pc, if_instr, if_pc_plus4, a, word_of(a), a + 32'd4);
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    total++; if (mem.req !== 1'b0) begin bad++; $display("[TB] FAIL stall_req got=%b exp=0", mem.req); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if ({mem.req, if_valid, if_pc, if_instr} !== {1'b0, 1'b1, 32'h8, word_of(32'h8)}) begin
        bad++; $display("[TB] FAIL stall_hold%0d got=%b/%b/%h/%h exp=0/1/8/%h", i, mem.req, if_valid, if_pc, if_instr, word_of(32'h8));
      end
    end
    stall = 1'b0;
    #1;
    total++; if ({mem.req, mem.addr} !== {1'b1, 32'hC}) begin bad++; $display("[TB] FAIL stall_release got=%b/%h exp=1/c", mem.req, mem.addr); end
    tick();
    mem.rvalid = 1'b1; mem.rdata = word_of(32'hC);
    total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_consume got=%b exp=0", if_valid); end
    tick();
    mem.rvalid = 1'b0;
    total++; if ({if_valid, if_pc} !== {1'b1, 32'hC}) begin bad++; $display("[TB] FAIL stall_next got=%b/%h exp=1/c", if_valid, if_pc); end
  endtask

  task automatic test_redirect_wait();
    #1;
    total++; if ({mem.req, mem.addr} !== {1'b1, 32'h10}) begin bad++; $display("[TB] FAIL redir_req got=%b/%h exp=1/10", mem.req, mem.addr); end
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    #1;
    total++; if (mem.req !== 1'b0) begin bad++; $display("[TB] FAIL redir_noreq got=%b exp=0", mem.req); end
    tick();
    redirect = 1'b0;
    total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL redir_flush got=%b exp=0", if_valid); end
    #1;
    total++; if (mem.req !== 1'b0) begin bad++; $display("[TB] FAIL redir_kill got=%b exp=0", mem.req); end
    mem.rvalid = 1'b1; mem.rdata = 32'hDEAD_BEEF;
    tick();
    mem.rvalid = 1'b0;
    total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL redir_drop got=%b/%h exp=0", if_valid, if_instr); end
    #1;
    total++; if ({mem.req, mem.addr} !== {1'b1, 32'h100}) begin bad++; $display("[TB] FAIL redir_target got=%b/%h exp=1/100", mem.req, mem.addr); end
    tick();
    mem.rvalid = 1'b1; mem.rdata = word_of(32'h100);
    tick();
    mem.rvalid = 1'b0;
    total++; if ({if_valid, if_pc, if_instr, if_pc_plus4} !== {1'b1, 32'h100, word_of(32'h100), 32'h104}) begin
      bad++; $display("[TB] FAIL redir_out got=%b/%h/%h/%h exp=1/100/%h/104", if_valid, if_pc, if_instr, if_pc_plus4, word_of(32'h100));
    end
  endtask

  task automatic test_redirect_rvalid();
    #1;
    total++; if ({mem.req, mem.addr} !== {1'b1, 32'h104}) begin bad++; $display("[TB] FAIL rr_req got=%b/%h exp=1/104", mem.req, mem.addr); end
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    mem.rvalid = 1'b1; mem.rdata = 32'hBAD0_0BAD;
    tick();
    redirect = 1'b0; mem.rvalid = 1'b0;
    total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL rr_drop got=%b/%h exp=0", if_valid, if_instr); end
    #1;
    total++; if ({mem.req, mem.addr} !== {1'b1, 32'h200}) begin bad++; $display("[TB] FAIL rr_target got=%b/%h exp=1/200", mem.req, mem.addr); end
    tick();
    mem.rvalid = 1'b1; mem.rdata = word_of(32'h200);
    tick();
    mem.rvalid = 1'b0;
    total++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h200, word_of(32'h200)}) begin
      bad++; $display("[TB] FAIL rr_out got=%b/%h/%h exp=1/200/%h", if_valid, if_pc, if_instr, word_of(32'h200));
    end
  endtask

  task automatic test_ready_low();
    redirect = 1'b1; redirect_pc = 32'h0000_0008;
    tick();
    redirect = 1'b0; mem.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({mem.req, mem.addr} !== {1'b1, 32'h8}) begin bad++; $display("[TB] FAIL rdy_hold%0d got=%b/%h exp=1/8", i, mem.req, mem.addr); end
      tick();
    end
    mem.ready = 1'b1;
    #1;
    total++; if ({mem.req, mem.addr} !== {1'b1, 32'h8}) begin bad++; $display("[TB] FAIL rdy_accept got=%b/%h exp=1/8", mem.req, mem.addr); end
    tick();
    mem.rvalid = 1'b1; mem.rdata = word_of(32'h8);
    tick();
    mem.rvalid = 1'b0;
    total++; if ({if_valid, if_pc} !== {1'b1, 32'h8}) begin bad++; $display("[TB] FAIL rdy_out got=%b/%h exp=1/8", if_valid, if_pc); end
    #1;
    total++; if ({mem.req, mem.addr} !== {1'b1, 32'hC}) begin bad++; $display("[TB] FAIL rdy_nextpc got=%b/%h exp=1/c", mem.req, mem.addr); end
  endtask

  task automatic test_wrap_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    #1;
    total++; if ({mem.req, mem.addr} !== {1'b1, 32'hFFFF_FFFC}) begin bad++; $display("[TB] FAIL wrap_req got=%b/%h exp=1/fffffffc", mem.req, mem.addr); end
    tick();
    mem.rvalid = 1'b1; mem.rdata = word_of(32'hFFFF_FFFC);
    tick();
    mem.rvalid = 1'b0;
    total++; if ({if_valid, if_pc, if_pc_plus4} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
      bad++; $display("[TB] FAIL wrap_out got=%b/%h/%h exp=1/fffffffc/0", if_valid, if_pc, if_pc_plus4);
    end
    #1;
    total++; if ({mem.req, mem.addr} !== {1'b1, 32'h0}) begin bad++; $display("[TB] FAIL wrap_pc got=%b/%h exp=1/0", mem.req, mem.addr); end
    tick();
    rst = 1'b1;
    tick();
    mem.rvalid = 1'b1; mem.rdata = 32'hBAD0_BAD0;
    #1;
    total++; if ({if_valid, if_pc, if_instr, mem.req, mem.addr} !== {1'b0, 32'h0, 32'h0000_0013, 1'b0, 32'h0}) begin
      bad++; $display("[TB] FAIL midrst got=%b/%h/%h/%b/%h exp=0/0/00000013/0/0", if_valid, if_pc, if_instr, mem.req, mem.addr);
    end
    tick();
    mem.rvalid = 1'b0; rst = 1'b0;
    total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL stale_drop got=%b/%h exp=0", if_valid, if_instr); end
    #1;
    total++; if ({mem.req, mem.addr} !== {1'b1, 32'h0}) begin bad++; $display("[TB] FAIL rst_restart got=%b/%h exp=1/0", mem.req, mem.addr); end
    tick();
    mem.rvalid = 1'b1; mem.rdata = word_of(32'h0);
    tick();
    mem.rvalid = 1'b0;
    total++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, word_of(32'h0)}) begin
      bad++; $display("[TB] FAIL rst_out got=%b/%h/%h exp=1/0/%h", if_valid, if_pc, if_instr, word_of(32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_ready_low();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before test sequence completed");
    $fatal(1, "[TB] timeout");
  end

endmodule
